weight_tile_sched: RTL

Tile-level scheduler for the weight FIFO path. On start it walks num_tiles weight tiles. For each tile it:
- fetches FIFO_DEPTH rows from weight memory into the weight FIFO;
- waits for the PE array to be ready;
- fires the single-cycle drain trigger into the FIFO output controller;
- waits for that controller's done before moving to the next tile.

It sits between the top-level layer sequencer and the weight FIFO / output controller pair.

---
 rtl/weight_fifo_pkg.sv | 17 +
 rtl/weight_tile_sched_if.sv | 41 ++++
 rtl/weight_row_addr_gen.sv | 38 +++
 rtl/weight_tile_sched.sv | 128 ++++++++++++
 4 files changed

// File: rtl/weight_fifo_pkg.sv
// Shared types and default sizes for the weight FIFO path.
package weight_fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_TILE_W     = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    WAIT_ARR = 3'd2,
    DRAIN    = 3'd3,
    FIN      = 3'd4
  } sched_state_e;

endpackage

// File: rtl/weight_tile_sched_if.sv
// Bundle of the scheduler's control, memory, FIFO and array/drain signals.
//
// Memory request handshake: a request transfers on a rising clk edge where
// mem_req_valid and mem_req_ready are both high. Once mem_req_valid is raised,
// it and mem_req_addr hold steady until that transfer; mem_req_valid never
// depends on mem_req_ready. Responses (mem_rsp_valid) carry no back-pressure.
interface weight_tile_sched_if
  import weight_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TILE_W     = DEF_TILE_W
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [TILE_W-1:0]     num_tiles;
  logic                  busy;
  logic                  done;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic                  fifo_push;
  logic                  array_ready;
  logic                  drain_start;
  logic                  drain_done;
  sched_state_e          dbg_state;

  modport master (
    input  start, base_addr, num_tiles, mem_req_ready, mem_rsp_valid,
           array_ready, drain_done,
    output busy, done, mem_req_valid, mem_req_addr, fifo_push, drain_start,
           dbg_state
  );

  modport slave (
    output start, base_addr, num_tiles, mem_req_ready, mem_rsp_valid,
           array_ready, drain_done,
    input  busy, done, mem_req_valid, mem_req_addr, fifo_push, drain_start,
           dbg_state
  );
endinterface

// File: rtl/weight_row_addr_gen.sv
// Row address generator: tile base plus row counter, advanced per handshake.
module weight_row_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ROW_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  next_tile_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ROW_W-1:0]      row_o
);
  logic [ADDR_WIDTH-1:0] tile_base_q;
  logic [ROW_W-1:0]      row_q;

  // Load the job base, step one tile (FIFO_DEPTH rows) per tile, count rows.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tile_base_q <= '0;
      row_q       <= '0;
    end else if (load_i) begin
      tile_base_q <= base_i;
      row_q       <= '0;
    end else if (next_tile_i) begin
      tile_base_q <= tile_base_q + ADDR_WIDTH'(FIFO_DEPTH);
      row_q       <= '0;
    end else if (adv_i) begin
      row_q <= row_q + ROW_W'(1);
    end
  end

  // Address wraps modulo 2^ADDR_WIDTH by plain truncation.
  assign addr_o = tile_base_q + ADDR_WIDTH'(row_q);
  assign row_o  = row_q;
endmodule

// File: rtl/weight_tile_sched.sv
// Tile scheduler: fill FIFO_DEPTH rows per tile, wait for the PE array,
// fire one drain pulse, wait for drain completion, repeat for num_tiles.
module weight_tile_sched
  import weight_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TILE_W     = DEF_TILE_W
) (
  input  logic                clk,
  input  logic                rstn,
  weight_tile_sched_if.master bus
);
  localparam int ROW_W = $clog2(FIFO_DEPTH) + 1;

  // FIFO_WIDTH only describes the data path; reject nonsense sizes early.
  if (FIFO_WIDTH < 1 || FIFO_DEPTH < 1) begin : g_param_check
    $error("weight_tile_sched: FIFO_WIDTH and FIFO_DEPTH must be >= 1");
  end

  sched_state_e          state_q, state_d;
  logic [TILE_W-1:0]     tile_q, tile_d;
  logic [TILE_W-1:0]     ntiles_q, ntiles_d;
  logic [ROW_W-1:0]      rsp_cnt_q, rsp_cnt_d;
  logic                  drain_q, drain_d;
  logic                  load, next_tile;
  logic [ROW_W-1:0]      req_cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid, req_hs, push;

  weight_row_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ROW_W      (ROW_W)
  ) u_addr_gen (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (load),
    .base_i      (bus.base_addr),
    .next_tile_i (next_tile),
    .adv_i       (req_hs),
    .addr_o      (req_addr),
    .row_o       (req_cnt)
  );

  // Valid comes from registered state and counter only, never from ready.
  assign req_valid = (state_q == FILL) && (req_cnt < ROW_W'(FIFO_DEPTH));
  assign req_hs    = req_valid && bus.mem_req_ready;
  assign push      = bus.mem_rsp_valid && rstn && (state_q == FILL);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tile_q    <= '0;
      ntiles_q  <= '0;
      rsp_cnt_q <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      ntiles_q  <= ntiles_d;
      rsp_cnt_q <= rsp_cnt_d;
      drain_q   <= drain_d;
    end
  end

  // Next-state logic; drain_d is only set on the WAIT_ARR -> DRAIN step.
  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    ntiles_d  = ntiles_q;
    rsp_cnt_d = rsp_cnt_q;
    drain_d   = 1'b0;
    load      = 1'b0;
    next_tile = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_tiles != '0) begin
            ntiles_d  = bus.num_tiles;
            tile_d    = '0;
            rsp_cnt_d = '0;
            load      = 1'b1;
            state_d   = FILL;
          end else begin
            state_d = FIN;
          end
        end
      end
      FILL: begin
        if (push) begin
          rsp_cnt_d = rsp_cnt_q + ROW_W'(1);
          if (rsp_cnt_q == ROW_W'(FIFO_DEPTH - 1)) state_d = WAIT_ARR;
        end
      end
      WAIT_ARR: begin
        if (bus.array_ready) begin
          drain_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.drain_done) begin
          tile_d = tile_q + TILE_W'(1);
          if ((tile_q + TILE_W'(1)) == ntiles_q) begin
            state_d = FIN;
          end else begin
            rsp_cnt_d = '0;
            next_tile = 1'b1;
            state_d   = FILL;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == FIN);
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = req_addr;
  assign bus.fifo_push     = push;
  assign bus.drain_start   = drain_q;
  assign bus.dbg_state     = state_q;
endmodule
